// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, the stream reader and the downstream sink.
// master = the reader (drives rd_en and the stream); slave = the surrounding FIFO/sink.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Turns the 1-cycle-latency FIFO read port into a valid/ready stream through a small
// prefetch ring buffer, tagging every BURST_LEN-th word with m_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         rd_clk,
  input  logic                         rst,
  fifo_stream_reader_if.master         bus,
  input  logic                         flush,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic [CNT_WIDTH-1:0]         words_out
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW:0]   DEPTH_L   = (CW+1)'(BUF_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] dataMem_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  lastMem_q;
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  inflight_q;
  logic [BW-1:0]         burst_q;
  logic [BW-1:0]         burst_d;
  logic [CNT_WIDTH-1:0]  words_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CW:0]           occupancy;

  // A read is only issued if the word can still land in the buffer, counting the
  // word already in flight and the slot freed by this cycle's pop.
  always_comb begin
    pop       = (count_q != '0) & bus.m_ready;
    push      = inflight_q & ~flush;
    occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = ~bus.fifo_empty & ~flush & ~rst & (occupancy < DEPTH_L);
    count_d   = count_q + CW'(push) - CW'(pop);
    burst_d   = (burst_q == LAST_BEAT) ? '0 : burst_q + BW'(1);
  end

  assign bus.fifo_rd_en = issue;
  assign bus.m_valid    = (count_q != '0);
  assign bus.m_data     = dataMem_q[head_q];
  assign bus.m_last     = lastMem_q[head_q];
  assign buf_count      = count_q;
  assign words_out      = words_q;

  // Flush still lets the current handshake count, but drops everything else,
  // including the word returning from last cycle's read.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      burst_q    <= '0;
      words_q    <= '0;
      lastMem_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        dataMem_q[i] <= '0;
      end
    end else begin
      inflight_q <= issue;
      if (pop) begin
        words_q <= words_q + CNT_WIDTH'(1);
      end
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        burst_q <= '0;
      end else begin
        if (push) begin
          dataMem_q[tail_q] <= bus.fifo_dout;
          lastMem_q[tail_q] <= (burst_q == LAST_BEAT);
          tail_q            <= tail_q + PTR_W'(1);
          burst_q           <= burst_d;
        end
        if (pop) begin
          head_q <= head_q + PTR_W'(1);
        end
        count_q <= count_d;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO model feeds the DUT while a queue-based
// reference of the stream rules is compared against it every cycle.
module tb_fifo_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int BLEN  = 4;
  localparam int CNTW  = 16;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } word_t;

  typedef struct {
    bit         rs;
    bit         r;
    bit         f;
    bit         expRd;
    bit         expValid;
    bit         chkData;
    logic [7:0] expData;
    bit         expLast;
    int         expCount;
    int         expWords;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            flushIn;
  logic            holdEmpty;
  logic [1:0]      bufCount;
  logic [CNTW-1:0] wordsOut;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BUF_DEPTH (DEPTH),
    .BURST_LEN (BLEN),
    .CNT_WIDTH (CNTW)
  ) dut (
    .rd_clk   (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flushIn),
    .buf_count(bufCount),
    .words_out(wordsOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] fifoMem [4096];
  int         wrCount = 0;
  int         rdIdx   = 0;
  logic [7:0] pending [$];

  assign bus.fifo_empty = holdEmpty || (rdIdx >= wrCount);

  // FIFO read port with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= fifoMem[rdIdx];
      rdIdx         <= rdIdx + 1;
    end
  end

  word_t      mBuf [$];
  bit         mInflight = 1'b0;
  logic [7:0] mInflightData;
  int         mBurst = 0;
  int         mWords = 0;
  int         mRd    = 0;
  word_t      seen [$];
  int         rdCount = 0;
  int         tests   = 0;
  int         failed  = 0;
  vec_t       vecs [13];

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(bit r, bit f, bit rs, bit he);
    @(negedge clk);
    while (pending.size() > 0 && wrCount < 4096) begin
      fifoMem[wrCount] = pending.pop_front();
      wrCount++;
    end
    bus.m_ready = r;
    flushIn     = f;
    rst         = rs;
    holdEmpty   = he;
    #1;
  endtask

  // Reference: buffer as a queue, one in-flight slot, burst position and handshake count.
  task automatic checkOutput();
    bit    expValid;
    bit    expPop;
    bit    empty;
    bit    expIssue;
    word_t w;
    expValid = (mBuf.size() != 0);
    expPop   = expValid && bus.m_ready;
    empty    = holdEmpty || (mRd >= wrCount);
    expIssue = !empty && !flushIn && !rst &&
               ((mBuf.size() + int'(mInflight) - int'(expPop)) < DEPTH);
    checkValue("rd_en", bus.fifo_rd_en, expIssue);
    checkValue("m_valid", bus.m_valid, expValid);
    checkValue("buf_count", bufCount, mBuf.size());
    checkValue("words_out", wordsOut, mWords & 32'hffff);
    if (expValid) begin
      checkValue("m_data", bus.m_data, mBuf[0].data);
      checkValue("m_last", bus.m_last, mBuf[0].last);
    end
    if (bus.m_valid && bus.m_ready) begin
      w.data = bus.m_data;
      w.last = bus.m_last;
      seen.push_back(w);
    end
    if (bus.fifo_rd_en) rdCount++;
    if (rst) begin
      mBuf.delete();
      mInflight = 1'b0;
      mBurst    = 0;
      mWords    = 0;
    end else begin
      if (expPop) begin
        w = mBuf.pop_front();
        mWords++;
      end
      if (flushIn) begin
        mBuf.delete();
        mBurst = 0;
      end else if (mInflight) begin
        w.data = mInflightData;
        w.last = (mBurst == BLEN - 1);
        mBuf.push_back(w);
        mBurst = (mBurst + 1) % BLEN;
      end
      mInflight = expIssue;
      if (expIssue) begin
        mInflightData = fifoMem[mRd];
        mRd++;
      end
    end
  endtask

  task automatic cycle(bit r, bit f, bit rs, bit he);
    applyStimulus(r, f, rs, he);
    checkOutput();
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && !(mRd == wrCount && mBuf.size() == 0 && !mInflight); i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1, 2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1, 3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 1, 4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1, 5};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h16, 1'b0, 1, 6};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h17, 1'b1, 1, 7};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8};

    bus.m_ready = 1'b0;
    flushIn     = 1'b0;
    rst         = 1'b1;
    holdEmpty   = 1'b0;
    for (int i = 0; i < 8; i++) pending.push_back(8'(8'h10 + i));
    while (pending.size() > 0) begin
      fifoMem[wrCount] = pending.pop_front();
      wrCount++;
    end
    @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].r, vecs[i].f, vecs[i].rs, 1'b0);
      checkValue($sformatf("vec%0d rd_en", i), bus.fifo_rd_en, vecs[i].expRd);
      checkValue($sformatf("vec%0d m_valid", i), bus.m_valid, vecs[i].expValid);
      checkValue($sformatf("vec%0d buf_count", i), bufCount, vecs[i].expCount);
      checkValue($sformatf("vec%0d words_out", i), wordsOut, vecs[i].expWords);
      if (vecs[i].chkData) begin
        checkValue($sformatf("vec%0d m_data", i), bus.m_data, vecs[i].expData);
        checkValue($sformatf("vec%0d m_last", i), bus.m_last, vecs[i].expLast);
      end
    end

    // Backpressure: only two reads fit, head held until ready returns.
    for (int i = 0; i < 8; i++) pending.push_back(8'(8'h10 + i));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    rdCount = 0;
    seen.delete();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("stall reads", rdCount, 2);
    checkValue("stall count", bufCount, 2);
    checkValue("stall head", bus.m_data, 8'h10);
    for (int i = 0; i < 40 && seen.size() < 8; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    checkValue("stall drained", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      checkValue($sformatf("stall word%0d", i), seen[i].data, 8'h10 + i);
      checkValue($sformatf("stall last%0d", i), seen[i].last, (i % 4) == 3);
    end

    // FIFO runs dry after three words, then refills mid-burst.
    for (int i = 0; i < 3; i++) pending.push_back(8'(8'h10 + i));
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    rdCount = 0;
    seen.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("dry reads", rdCount, 3);
    checkValue("dry words", seen.size(), 3);
    checkValue("dry valid", bus.m_valid, 1'b0);
    if (seen.size() == 3) checkValue("dry tail", seen[2].data, 8'h12);
    for (int i = 3; i < 6; i++) pending.push_back(8'(8'h10 + i));
    for (int i = 0; i < 12 && seen.size() < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("refill seen", seen.size() >= 4, 1'b1);
    if (seen.size() >= 4) begin
      checkValue("refill data", seen[3].data, 8'h13);
      checkValue("refill last", seen[3].last, 1'b1);
    end

    // Flush with one word buffered and one in flight.
    drain();
    for (int i = 0; i < 8; i++) pending.push_back(8'(8'h30 + i));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("preflush count", bufCount, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("postflush valid", bus.m_valid, 1'b0);
    checkValue("postflush count", bufCount, 0);
    seen.delete();
    for (int i = 0; i < 20 && seen.size() < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("flush burst seen", seen.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checkValue($sformatf("flush word%0d", i), seen[i].data, 8'h32 + i);
      checkValue($sformatf("flush last%0d", i), seen[i].last, i == 3);
    end

    // Reset with a full buffer, then resume.
    drain();
    for (int i = 0; i < 8; i++) pending.push_back(8'(8'h40 + i));
    for (int i = 0; i < 10 && bufCount != 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("prereset count", bufCount, 2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("postreset valid", bus.m_valid, 1'b0);
    checkValue("postreset words", wordsOut, 0);
    seen.delete();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("resume seen", seen.size() > 0, 1'b1);
    if (seen.size() > 0) checkValue("resume first", seen[0].data, 8'h42);

    // Random traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      if ((wrCount - mRd) < 6 && $urandom_range(0, 2) != 0) pending.push_back(8'($urandom));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
